dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_if.sv | 51 +++++
 rtl/dmem_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: bundles the two requester ports and the DMEM command/response
// signals of the data-memory arbiter.
`default_nettype none

interface dmem_arb_if;
  logic        M0_REQ;
  logic        M0_DRW;
  logic [31:0] M0_ADDR;
  logic [1:0]  M0_SIZE;
  logic [31:0] M0_WDATA;
  logic [31:0] M0_RDATA;
  logic        M0_DONE;
  logic        STALL;

  logic        M1_REQ;
  logic        M1_DRW;
  logic [31:0] M1_ADDR;
  logic [1:0]  M1_SIZE;
  logic [31:0] M1_WDATA;
  logic [31:0] M1_RDATA;
  logic        M1_DONE;

  logic        ERR;

  logic        REQ;
  logic        DRW;
  logic [31:0] DADDR;
  logic [1:0]  DSIZE;
  logic [31:0] DOUT;
  logic [31:0] DIN;
  logic        DRDY;

  // Arbiter side: serves the two requesters and drives the DMEM command.
  modport slave (
    input  M0_REQ, M0_DRW, M0_ADDR, M0_SIZE, M0_WDATA,
    input  M1_REQ, M1_DRW, M1_ADDR, M1_SIZE, M1_WDATA,
    input  DIN, DRDY,
    output M0_RDATA, M0_DONE, STALL, M1_RDATA, M1_DONE, ERR,
    output REQ, DRW, DADDR, DSIZE, DOUT
  );

  modport master (
    output M0_REQ, M0_DRW, M0_ADDR, M0_SIZE, M0_WDATA,
    output M1_REQ, M1_DRW, M1_ADDR, M1_SIZE, M1_WDATA,
    output DIN, DRDY,
    input  M0_RDATA, M0_DONE, STALL, M1_RDATA, M1_DONE, ERR,
    input  REQ, DRW, DADDR, DSIZE, DOUT
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arb.sv
// dmem_arb: two-port round-robin data-memory arbiter with access timeout.
// Revision: 1.0
`default_nettype none

module dmem_arb #(
  parameter int TIMEOUT = 16
) (
  input  wire logic   CLK,
  input  wire logic   RST,
  dmem_arb_if.slave   bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACC  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic        r_last;
  logic        r_owner;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_drw;
  logic [31:0] r_daddr;
  logic [1:0]  r_dsize;
  logic [31:0] r_dout;
  logic [31:0] r_rdata;
  logic        r_m0_done;
  logic        r_m1_done;
  logic        r_err;

  logic        w_any;
  logic        w_id;
  logic        w_drw;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [31:0] w_wdata;
  logic [31:0] w_mask;
  logic        w_tmo;

  // With both ports requesting, LAST=1 favours port 0, so the winner id is ~LAST.
  always_comb begin
    w_any = bus.M0_REQ | bus.M1_REQ;
    if (bus.M0_REQ && bus.M1_REQ) w_id = ~r_last;
    else                          w_id = bus.M1_REQ;
    w_drw   = w_id ? bus.M1_DRW   : bus.M0_DRW;
    w_addr  = w_id ? bus.M1_ADDR  : bus.M0_ADDR;
    w_size  = w_id ? bus.M1_SIZE  : bus.M0_SIZE;
    w_wdata = w_id ? bus.M1_WDATA : bus.M0_WDATA;
    case (w_size)
      2'b01:   w_mask = 32'h0000_00FF;
      2'b10:   w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    w_tmo = (r_cnt == c_TMO_LAST);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= c_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_cnt     <= 8'd0;
      r_req     <= 1'b0;
      r_drw     <= 1'b0;
      r_daddr   <= 32'd0;
      r_dsize   <= 2'd0;
      r_dout    <= 32'd0;
      r_rdata   <= 32'd0;
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_owner <= w_id;
            r_last  <= w_id;
            r_cnt   <= 8'd0;
            r_drw   <= w_drw;
            r_dsize <= w_size;
            r_daddr <= w_addr & w_mask;
            r_dout  <= w_wdata & w_mask;
            if (w_size == 2'b00) begin
              // Illegal size completes with an error, never touching DMEM.
              r_state   <= c_RESP;
              r_err     <= 1'b1;
              r_rdata   <= 32'd0;
              r_m0_done <= ~w_id;
              r_m1_done <= w_id;
            end else begin
              r_state <= c_ACC;
              r_req   <= 1'b1;
            end
          end
        end
        c_ACC: begin
          if (bus.DRDY || w_tmo) begin
            r_state   <= c_RESP;
            r_req     <= 1'b0;
            r_err     <= ~bus.DRDY;
            r_rdata   <= (bus.DRDY && r_drw) ? bus.DIN : 32'd0;
            r_m0_done <= ~r_owner;
            r_m1_done <= r_owner;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_RESP: begin
          r_state   <= c_IDLE;
          r_err     <= 1'b0;
          r_rdata   <= 32'd0;
          r_m0_done <= 1'b0;
          r_m1_done <= 1'b0;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.REQ      = r_req;
  assign bus.DRW      = r_drw;
  assign bus.DADDR    = r_daddr;
  assign bus.DSIZE    = r_dsize;
  assign bus.DOUT     = r_dout;
  assign bus.ERR      = r_err;
  assign bus.M0_DONE  = r_m0_done;
  assign bus.M1_DONE  = r_m1_done;
  assign bus.M0_RDATA = r_m0_done ? r_rdata : 32'd0;
  assign bus.M1_RDATA = r_m1_done ? r_rdata : 32'd0;
  assign bus.STALL    = bus.M0_REQ & ~r_m0_done;

endmodule

`default_nettype wire
